sdram16_device_model: RTL and testbench

//  Synthesizable, cycle-accurate responder for the 16-bit SDR SDRAM command/data pins driven by our SDRAM controllers.

---
 rtl/sdram16_device_model.sv | 233 +++++++++++++++++++++++
 tb/tb_sdram16_device_model.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram16_device_model.sv
// sdram16_device_model
// Pin-level responder for a 16-bit SDR SDRAM. Decodes commands, tracks open rows
// per bank and the mode register, serves sequential bursts from a backing array
// and raises sticky protocol-violation flags.
// Optional feature: define SDRAM_MODEL_TIMING_EN to enable TRCD/TRP/TRFC checking.
//
// Burst engine states:
//   state            | meaning
//   idle             | r_bst_active=0, no burst words pending
//   bursting         | r_bst_active=1, r_bst_left words still to transfer
module sdram16_device_model #(
  parameter int MEM_AW = 16,
  parameter int TRCD   = 2,
  parameter int TRP    = 2,
  parameter int TRFC   = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  input  logic [1:0]  dqm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [12:0] mode_reg,
  output logic        mode_valid,
  output logic [5:0]  err
);

  logic [15:0] r_mem [0:(1<<MEM_AW)-1];

  logic [3:0]  r_bank_open;
  logic [12:0] r_bank_row [4];
  logic [12:0] r_mode_reg;
  logic        r_mode_valid;
  logic [5:0]  r_err;

  logic        r_bst_active, r_bst_write, r_bst_ap;
  logic [1:0]  r_bst_ba;
  logic [12:0] r_bst_row;
  logic [9:0]  r_bst_col;
  logic [3:0]  r_bst_left;

  logic        r_p0_v, r_p1_v;
  logic [15:0] r_p0_d, r_p1_d;
  logic [15:0] r_dq_out;
  logic        r_dq_oe;

  logic        w_sel, w_is_act, w_is_rd, w_is_wr, w_is_pre, w_is_ref, w_is_mrs, w_rw;
  logic        w_act_ok, w_rw_ok, w_ref_ok;
  logic [3:0]  w_bl;
  logic [2:0]  w_bl_mask;
  logic        w_cl3;
  logic        w_bst_go, w_bst_last, w_bst_trunc;
  logic [3:0]  w_open_mask, w_close_mask;
  logic        w_mem_we, w_push;
  logic [MEM_AW-1:0] w_cmd_idx, w_bst_idx, w_mem_idx, w_rd_idx;
  logic [15:0] w_rd_data;
  logic        w_trcd_viol, w_trp_viol;

  // Next column inside the BL-aligned block (sequential wrap).
  function automatic logic [9:0] f_col_next(input logic [9:0] col, input logic [2:0] mask);
    logic [2:0] inc;
    inc = col[2:0] + 3'd1;
    return {col[9:3], (col[2:0] & ~mask) | (inc & mask)};
  endfunction

  assign w_sel    = cke & ~cs_n;
  assign w_is_act = w_sel & ({ras_n, cas_n, we_n} == 3'b011);
  assign w_is_rd  = w_sel & ({ras_n, cas_n, we_n} == 3'b101);
  assign w_is_wr  = w_sel & ({ras_n, cas_n, we_n} == 3'b100);
  assign w_is_pre = w_sel & ({ras_n, cas_n, we_n} == 3'b010);
  assign w_is_ref = w_sel & ({ras_n, cas_n, we_n} == 3'b001);
  assign w_is_mrs = w_sel & ({ras_n, cas_n, we_n} == 3'b000);
  assign w_rw     = w_is_rd | w_is_wr;

  assign w_act_ok = w_is_act & r_mode_valid;
  assign w_rw_ok  = w_rw & r_mode_valid & r_bank_open[ba];
  assign w_ref_ok = w_is_ref & ~(|r_bank_open);

  // Burst length and CAS latency decoded from the mode register.
  always_comb begin
    case (r_mode_reg[2:0])
      3'd0:    w_bl = 4'd1;
      3'd1:    w_bl = 4'd2;
      3'd3:    w_bl = 4'd8;
      default: w_bl = 4'd4;
    endcase
  end
  assign w_bl_mask = w_bl[2:0] - 3'd1;
  assign w_cl3     = (r_mode_reg[6:4] == 3'd3);

  assign w_bst_go    = cke & r_bst_active;
  assign w_bst_last  = (r_bst_left == 4'd1);
  assign w_bst_trunc = w_is_pre & r_bst_active & (addr[10] | (ba == r_bst_ba));

  assign w_open_mask = w_act_ok ? (4'b0001 << ba) : 4'b0000;

  // Banks closed this edge: auto-precharge at end of burst or explicit PRE.
  always_comb begin
    w_close_mask = 4'b0000;
    if (w_bst_go && w_bst_last && r_bst_ap) w_close_mask[r_bst_ba] = 1'b1;
    if (w_rw_ok && (w_bl == 4'd1) && addr[10]) w_close_mask[ba] = 1'b1;
    if (w_is_pre) w_close_mask = w_close_mask | (addr[10] ? 4'b1111 : (4'b0001 << ba));
    w_close_mask = w_close_mask & r_bank_open;
  end

  assign w_cmd_idx = MEM_AW'({ba, r_bank_row[ba], addr[9:0]});
  assign w_bst_idx = MEM_AW'({r_bst_ba, r_bst_row, r_bst_col});

  // A new WR owns the single write port; otherwise an in-flight write burst uses it.
  assign w_mem_we  = ~rst_i & ((w_is_wr & w_rw_ok) | (w_bst_go & r_bst_write));
  assign w_mem_idx = (w_is_wr & w_rw_ok) ? w_cmd_idx : w_bst_idx;
  // A new RD replaces the burst read word; a new WR drops it.
  assign w_push    = (w_is_rd & w_rw_ok) | (w_bst_go & ~r_bst_write & ~(w_is_wr & w_rw_ok));
  assign w_rd_idx  = (w_is_rd & w_rw_ok) ? w_cmd_idx : w_bst_idx;
  assign w_rd_data = r_mem[w_rd_idx];

`ifdef SDRAM_MODEL_TIMING_EN
  logic [7:0] r_trcd_cnt [4];
  logic [7:0] r_trp_cnt  [4];
  logic [7:0] r_trfc_cnt;

  assign w_trcd_viol = w_rw_ok & (r_trcd_cnt[ba] != 8'd0);
  assign w_trp_viol  = (w_act_ok & (r_trp_cnt[ba] != 8'd0)) |
                       (w_sel & ({ras_n, cas_n, we_n} != 3'b111) & (r_trfc_cnt != 8'd0));

  // Per-bank terminal-count timers, reloaded by ACT / close / REF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        r_trcd_cnt[i] <= 8'd0;
        r_trp_cnt[i]  <= 8'd0;
      end
      r_trfc_cnt <= 8'd0;
    end else if (cke) begin
      for (int i = 0; i < 4; i++) begin
        if (r_trcd_cnt[i] != 8'd0) r_trcd_cnt[i] <= r_trcd_cnt[i] - 8'd1;
        if (r_trp_cnt[i] != 8'd0)  r_trp_cnt[i]  <= r_trp_cnt[i] - 8'd1;
        if (w_open_mask[i])  r_trcd_cnt[i] <= 8'(TRCD - 1);
        if (w_close_mask[i]) r_trp_cnt[i]  <= 8'(TRP - 1);
      end
      if (r_trfc_cnt != 8'd0) r_trfc_cnt <= r_trfc_cnt - 8'd1;
      if (w_ref_ok) r_trfc_cnt <= 8'(TRFC - 1);
    end
  end
`else
  assign w_trcd_viol = 1'b0;
  assign w_trp_viol  = 1'b0;
`endif

  // Backing array write with per-byte mask; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      if (!dqm[0]) r_mem[w_mem_idx][7:0]  <= dq_in[7:0];
      if (!dqm[1]) r_mem[w_mem_idx][15:8] <= dq_in[15:8];
    end
  end

  // Command decode, bank/mode tracking, burst engine, read pipeline and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bank_open  <= 4'b0000;
      for (int i = 0; i < 4; i++) r_bank_row[i] <= 13'd0;
      r_mode_reg   <= 13'd0;
      r_mode_valid <= 1'b0;
      r_err        <= 6'd0;
      r_bst_active <= 1'b0;
      r_bst_write  <= 1'b0;
      r_bst_ap     <= 1'b0;
      r_bst_ba     <= 2'd0;
      r_bst_row    <= 13'd0;
      r_bst_col    <= 10'd0;
      r_bst_left   <= 4'd0;
      r_p0_v       <= 1'b0;
      r_p1_v       <= 1'b0;
      r_p0_d       <= 16'd0;
      r_p1_d       <= 16'd0;
      r_dq_out     <= 16'd0;
      r_dq_oe      <= 1'b0;
    end else if (cke) begin
      r_bank_open <= (r_bank_open & ~w_close_mask) | w_open_mask;
      if (w_act_ok) r_bank_row[ba] <= addr;

      if (w_bst_go) begin
        r_bst_left <= r_bst_left - 4'd1;
        r_bst_col  <= f_col_next(r_bst_col, w_bl_mask);
        if (w_bst_last) r_bst_active <= 1'b0;
      end
      if (w_bst_trunc) r_bst_active <= 1'b0;
      if (w_rw_ok) begin
        r_bst_active <= (w_bl != 4'd1);
        r_bst_write  <= w_is_wr;
        r_bst_ap     <= addr[10];
        r_bst_ba     <= ba;
        r_bst_row    <= r_bank_row[ba];
        r_bst_col    <= f_col_next(addr[9:0], w_bl_mask);
        r_bst_left   <= w_bl - 4'd1;
      end

      if (w_is_mrs) begin
        r_mode_reg   <= addr;
        r_mode_valid <= 1'b1;
      end

      if (w_is_act & r_mode_valid & r_bank_open[ba])  r_err[0] <= 1'b1;
      if (w_rw & r_mode_valid & ~r_bank_open[ba])     r_err[1] <= 1'b1;
      if (w_is_ref & (|r_bank_open))                  r_err[2] <= 1'b1;
      if ((w_is_act | w_rw) & ~r_mode_valid)          r_err[3] <= 1'b1;
      if (w_trcd_viol)                                r_err[4] <= 1'b1;
      if (w_trp_viol)                                 r_err[5] <= 1'b1;

      r_p0_v <= w_push;
      if (w_push) r_p0_d <= w_rd_data;
      r_p1_v <= r_p0_v;
      r_p1_d <= r_p0_d;
      r_dq_oe <= w_cl3 ? r_p1_v : r_p0_v;
      if (w_cl3 ? r_p1_v : r_p0_v) r_dq_out <= w_cl3 ? r_p1_d : r_p0_d;
    end
  end

  assign dq_out     = r_dq_out;
  assign dq_oe      = r_dq_oe;
  assign mode_reg   = r_mode_reg;
  assign mode_valid = r_mode_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_sdram16_device_model.sv
// Directed testbench for sdram16_device_model: a per-cycle vector table for the
// main burst behaviour plus hand-written sequences for errors, reset and freeze.
module tb_sdram16_device_model;

  logic        clk_i = 1'b0;
  logic        rst_i, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba, dqm;
  logic [12:0] addr;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, mode_valid;
  logic [12:0] mode_reg;
  logic [5:0]  err;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                         C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_MRS = 4'b0000;
`ifdef SDRAM_MODEL_TIMING_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  sdram16_device_model dut (
    .clk_i(clk_i), .rst_i(rst_i), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .dqm(dqm), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .mode_reg(mode_reg), .mode_valid(mode_valid),
    .err(err)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dq;
    logic        exp_oe;
    logic [15:0] exp_dq;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                     input logic [1:0] m, input logic [15:0] d, input logic eo,
                     input logic [15:0] ed);
    vec_t v;
    v.cmd = c; v.ba = b; v.addr = a; v.dqm = m; v.dq = d; v.exp_oe = eo; v.exp_dq = ed;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive pins mid-cycle, then return just after the sampling edge.
  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] d);
    @(negedge clk_i);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b; addr = a; dqm = m; dq_in = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = C_NOP;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic chk_word(input string name, input logic [15:0] exp);
    check({name, "_oe"}, {31'd0, dq_oe}, 32'd1);
    check({name, "_dq"}, {16'd0, dq_out}, {16'd0, exp});
  endtask

  initial begin
    rst_i = 1'b1; cke = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = C_NOP;
    ba = 2'd0; addr = 13'd0; dqm = 2'b00; dq_in = 16'd0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("rst_dq_out", {16'd0, dq_out}, 32'd0);
    check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    check("rst_mode_reg", {19'd0, mode_reg}, 32'd0);
    check("rst_mode_valid", {31'd0, mode_valid}, 32'd0);
    check("rst_err", {26'd0, err}, 32'd0);

    // Main table: MRS CL2/BL4, write/read bursts, wrap order, byte masks, CL3/BL1.
    add(C_MRS, 2'd0, 13'h022, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_ACT, 2'd1, 13'h123, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_WR,  2'd1, 13'h410, 2'b00, 16'h1111, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h2222, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h3333, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h4444, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_ACT, 2'd1, 13'h123, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_RD,  2'd1, 13'h010, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h1111);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h2222);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h3333);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h4444);
    add(C_WR,  2'd1, 13'h012, 2'b00, 16'hA001, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'hA002, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'hA003, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'hA004, 1'b0, 16'h0000);
    add(C_RD,  2'd1, 13'h010, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA003);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA004);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA001);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA002);
    add(C_RD,  2'd1, 13'h012, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA001);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA002);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA003);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hA004);
    add(C_WR,  2'd1, 13'h020, 2'b00, 16'h1234, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h5678, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h9ABC, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'hDEF0, 1'b0, 16'h0000);
    add(C_WR,  2'd1, 13'h020, 2'b10, 16'hABCD, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b11, 16'hFFFF, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b01, 16'hFFFF, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b11, 16'h0000, 1'b0, 16'h0000);
    add(C_RD,  2'd1, 13'h420, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h12CD);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h5678);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hFFBC);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'hDEF0);
    add(C_MRS, 2'd0, 13'h030, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_ACT, 2'd1, 13'h123, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_RD,  2'd1, 13'h020, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h12CD);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    add(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0000);

    foreach (tv[i]) begin
      drive(tv[i].cmd, tv[i].ba, tv[i].addr, tv[i].dqm, tv[i].dq);
      check($sformatf("vec%0d_oe", i), {31'd0, dq_oe}, {31'd0, tv[i].exp_oe});
      if (tv[i].exp_oe)
        check($sformatf("vec%0d_dq", i), {16'd0, dq_out}, {16'd0, tv[i].exp_dq});
      check($sformatf("vec%0d_err", i), {26'd0, err}, 32'd0);
    end
    check("tbl_mode_reg", {19'd0, mode_reg}, 32'h030);
    check("tbl_mode_valid", {31'd0, mode_valid}, 32'd1);

    // RD before MRS, then RD to an idle bank.
    do_reset();
    drive(C_RD, 2'd0, 13'h000, 2'b00, 16'd0);
    check("rd_nomode_err", {26'd0, err}, 32'h08);
    for (int i = 0; i < 3; i++) begin
      nop();
      check("rd_nomode_oe", {31'd0, dq_oe}, 32'd0);
    end
    drive(C_MRS, 2'd0, 13'h022, 2'b00, 16'd0);
    drive(C_RD, 2'd0, 13'h000, 2'b00, 16'd0);
    check("rd_idle_err", {26'd0, err}, 32'h0A);
    for (int i = 0; i < 3; i++) begin
      nop();
      check("rd_idle_oe", {31'd0, dq_oe}, 32'd0);
    end

    // ACT to open bank, REF with bank open, REF then immediate ACT.
    do_reset();
    drive(C_MRS, 2'd0, 13'h022, 2'b00, 16'd0);
    drive(C_ACT, 2'd0, 13'h000, 2'b00, 16'd0);
    nop(); nop();
    drive(C_ACT, 2'd0, 13'h000, 2'b00, 16'd0);
    check("act_open_err", {26'd0, err}, 32'h01);
    drive(C_REF, 2'd0, 13'h000, 2'b00, 16'd0);
    check("ref_open_err", {26'd0, err}, 32'h05);
    drive(C_PRE, 2'd0, 13'h400, 2'b00, 16'd0);
    nop(); nop();
    drive(C_REF, 2'd0, 13'h000, 2'b00, 16'd0);
    check("ref_ok_err", {26'd0, err}, 32'h05);
    drive(C_ACT, 2'd0, 13'h000, 2'b00, 16'd0);
    check("trfc_err", {26'd0, err}, TIMING ? 32'h25 : 32'h05);

    // ACT then RD one cycle later; data still returned; reset mid-read.
    do_reset();
    drive(C_MRS, 2'd0, 13'h022, 2'b00, 16'd0);
    drive(C_ACT, 2'd1, 13'h123, 2'b00, 16'd0);
    drive(C_RD, 2'd1, 13'h010, 2'b00, 16'd0);
    check("trcd_err", {26'd0, err}, TIMING ? 32'h10 : 32'h00);
    nop();
    chk_word("trcd_w0", 16'hA003);
    do_reset();
    check("midrst_oe", {31'd0, dq_oe}, 32'd0);
    check("midrst_err", {26'd0, err}, 32'd0);
    check("midrst_mode_valid", {31'd0, mode_valid}, 32'd0);

    // cke=0 freezes the burst and ignores pins.
    drive(C_MRS, 2'd0, 13'h022, 2'b00, 16'd0);
    drive(C_ACT, 2'd1, 13'h123, 2'b00, 16'd0);
    nop();
    drive(C_RD, 2'd1, 13'h020, 2'b00, 16'd0);
    nop();
    chk_word("cke_w0", 16'h12CD);
    cke = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(C_RD, 2'd1, 13'h010, 2'b00, 16'd0);
      chk_word("cke_hold", 16'h12CD);
    end
    cke = 1'b1;
    nop(); chk_word("cke_w1", 16'h5678);
    nop(); chk_word("cke_w2", 16'hFFBC);
    nop(); chk_word("cke_w3", 16'hDEF0);
    nop(); check("cke_end_oe", {31'd0, dq_oe}, 32'd0);

    // PRE truncates after the current word; a new RD truncates the old burst.
    drive(C_RD, 2'd1, 13'h020, 2'b00, 16'd0);
    drive(C_PRE, 2'd1, 13'h000, 2'b00, 16'd0);
    chk_word("pre_w0", 16'h12CD);
    nop(); chk_word("pre_w1", 16'h5678);
    nop(); check("pre_end_oe", {31'd0, dq_oe}, 32'd0);
    drive(C_ACT, 2'd1, 13'h123, 2'b00, 16'd0);
    nop();
    drive(C_RD, 2'd1, 13'h020, 2'b00, 16'd0);
    nop(); chk_word("trunc_a0", 16'h12CD);
    drive(C_RD, 2'd1, 13'h010, 2'b00, 16'd0);
    chk_word("trunc_a1", 16'h5678);
    nop(); chk_word("trunc_b0", 16'hA003);
    nop(); chk_word("trunc_b1", 16'hA004);
    nop(); chk_word("trunc_b2", 16'hA001);
    nop(); chk_word("trunc_b3", 16'hA002);
    nop(); check("trunc_end_oe", {31'd0, dq_oe}, 32'd0);
    check("final_err", {26'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
